// File: rtl/seg7_pkg.sv
// Shared segment encodings and the BCD-to-segment mapping for the 7-segment display path.
// Segment bit order is a..g in bits 0..6 with the decimal point in bit 7.
package seg7_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7C;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h67;

  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam logic [7:0] SEG_ALL   = 8'hFF;

  // 4511 behaviour: non-decimal codes A..F show nothing.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
    logic [6:0] code;
    code = 7'h00;
    case (bcd)
      4'd0: code = SEG_0;
      4'd1: code = SEG_1;
      4'd2: code = SEG_2;
      4'd3: code = SEG_3;
      4'd4: code = SEG_4;
      4'd5: code = SEG_5;
      4'd6: code = SEG_6;
      4'd7: code = SEG_7;
      4'd8: code = SEG_8;
      4'd9: code = SEG_9;
      default: code = 7'h00;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational single-digit decoder with lamp test, blanking and leading-zero blank priority.
// Output is active-high; polarity is applied by the caller at its output register.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       dp,
  input  logic       lt_n,
  input  logic       bi_n,
  input  logic       blank,
  output logic [7:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!lt_n) begin
      seg = SEG_ALL;
    end else if (!bi_n || blank) begin
      seg = SEG_BLANK;
    end else begin
      seg[SEG_G:SEG_A] = bcd_to_seg(bcd);
      seg[SEG_DP]      = dp;
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed multi-digit 7-segment driver: input latch, prescaled scan, leading-zero
// blanking and a single output register that keeps seg, dig and scan_idx aligned.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int CLK_DIV        = 50000,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [4*DIGITS-1:0]                       bcd_in,
  input  logic [DIGITS-1:0]                         dp_in,
  input  logic                                      le,
  input  logic                                      lt_n,
  input  logic                                      bi_n,
  input  logic                                      lzb_en,
  output logic [7:0]                                seg,
  output logic [DIGITS-1:0]                         dig,
  output logic [(DIGITS > 1 ? $clog2(DIGITS) : 1)-1:0] scan_idx
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  // XOR masks: an all-zero active-high pattern becomes the "off" level after polarity.
  localparam logic [7:0]        SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] DIG_OFF = (DIG_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : '0;

  logic [PW-1:0]       presc_reg;
  logic                tick;
  logic [IW-1:0]       idx_next;
  logic [4*DIGITS-1:0] bcd_lat_reg;
  logic [DIGITS-1:0]   dp_lat_reg;
  logic [3:0]          digit_lat [DIGITS];
  logic [DIGITS:1]     zero_above;
  logic [DIGITS-1:0]   blank_vec;
  logic [DIGITS-1:0]   dig_onehot;
  logic [7:0]          seg_raw;

  assign tick = (presc_reg == PW'(CLK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       presc_reg <= '0;
    else if (tick) presc_reg <= '0;
    else           presc_reg <= presc_reg + 1'b1;
  end

  always_comb begin
    idx_next = scan_idx;
    if (tick) begin
      if (scan_idx == IW'(DIGITS - 1)) idx_next = '0;
      else                             idx_next = scan_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd_lat_reg <= '0;
      dp_lat_reg  <= '0;
    end else if (!le) begin
      bcd_lat_reg <= bcd_in;
      dp_lat_reg  <= dp_in;
    end
  end

  // zero_above[i] is set when latched digits DIGITS-1 down to i are all zero.
  assign zero_above[DIGITS] = 1'b1;
  assign blank_vec[0]       = 1'b0;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign digit_lat[gi] = bcd_lat_reg[4*gi +: 4];
      if (gi > 0) begin : g_lzb
        assign zero_above[gi] = zero_above[gi+1] && (digit_lat[gi] == 4'd0);
        assign blank_vec[gi]  = lzb_en && zero_above[gi];
      end
    end
  endgenerate

  assign dig_onehot = DIGITS'(1) << idx_next;

  seg7_decode u_decode (
    .bcd   (digit_lat[idx_next]),
    .dp    (dp_lat_reg[idx_next]),
    .lt_n  (lt_n),
    .bi_n  (bi_n),
    .blank (blank_vec[idx_next]),
    .seg   (seg_raw)
  );

  // Everything is derived from idx_next so the three outputs always describe the same digit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg      <= SEG_OFF;
      dig      <= DIG_OFF;
      scan_idx <= '0;
    end else begin
      seg      <= seg_raw ^ SEG_OFF;
      dig      <= dig_onehot ^ DIG_OFF;
      scan_idx <= idx_next;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench: a CLK_DIV=4 default-polarity instance and a CLK_DIV=1 inverted-polarity
// instance share stimulus; expected scan position comes from a cycle count since reset release.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] bcd_in;
  logic [3:0]  dp_in;
  logic        le, lt_n, bi_n, lzb_en;
  logic [7:0]  seg_a, seg_b;
  logic [3:0]  dig_a, dig_b;
  logic [1:0]  idx_a, idx_b;

  int tests = 0;
  int fails = 0;
  int cyc;

  logic [7:0] t1234 [4] = '{8'h66, 8'h4F, 8'h5B, 8'h06};

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  seg7_scan_driver #(.DIGITS(4), .CLK_DIV(4), .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(1)) dut_a (
    .clk(clk), .rst(rst), .bcd_in(bcd_in), .dp_in(dp_in), .le(le), .lt_n(lt_n),
    .bi_n(bi_n), .lzb_en(lzb_en), .seg(seg_a), .dig(dig_a), .scan_idx(idx_a)
  );

  seg7_scan_driver #(.DIGITS(4), .CLK_DIV(1), .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(0)) dut_b (
    .clk(clk), .rst(rst), .bcd_in(bcd_in), .dp_in(dp_in), .le(le), .lt_n(lt_n),
    .bi_n(bi_n), .lzb_en(lzb_en), .seg(seg_b), .dig(dig_b), .scan_idx(idx_b)
  );

  task automatic test_reset();
    int e;
    bit found;
    rst = 1'b1; bcd_in = 16'h1234; dp_in = 4'b0000;
    le = 1'b0; lt_n = 1'b1; bi_n = 1'b1; lzb_en = 1'b0;
    repeat (2) @(negedge clk);
    tests++; if (seg_a !== 8'h00) begin fails++; $display("FAIL rst_seg_a: got %h expected 00", seg_a); end
    tests++; if (dig_a !== 4'b1111) begin fails++; $display("FAIL rst_dig_a: got %b expected 1111", dig_a); end
    tests++; if (idx_a !== 2'd0) begin fails++; $display("FAIL rst_idx_a: got %0d expected 0", idx_a); end
    tests++; if (seg_b !== 8'hFF) begin fails++; $display("FAIL rst_seg_b: got %h expected ff", seg_b); end
    tests++; if (dig_b !== 4'b0000) begin fails++; $display("FAIL rst_dig_b: got %b expected 0000", dig_b); end
    $display("[TB] reset held: seg_a=%h dig_a=%b seg_b=%h dig_b=%b", seg_a, dig_a, seg_b, dig_b);
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      e = (k == 4) ? 1 : 0;
      tests++; if (idx_a !== 2'(e)) begin fails++; $display("FAIL first_tick k=%0d: got %0d expected %0d", k, idx_a, e); end
    end
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (idx_a == 2'd2) found = 1'b1;
      else @(negedge clk);
    end
    tests++; if (!found) begin fails++; $display("FAIL wait_idx2: idx_a=%0d expected 2 within 40 clks", idx_a); end
    #2 rst = 1'b1;
    #1;
    tests++; if (seg_a !== 8'h00) begin fails++; $display("FAIL async_rst_seg: got %h expected 00", seg_a); end
    tests++; if (dig_a !== 4'b1111) begin fails++; $display("FAIL async_rst_dig: got %b expected 1111", dig_a); end
    tests++; if (idx_a !== 2'd0) begin fails++; $display("FAIL async_rst_idx: got %0d expected 0", idx_a); end
    $display("[TB] async reset mid-scan: seg_a=%h dig_a=%b idx_a=%0d", seg_a, dig_a, idx_a);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests++; if (idx_a !== 2'd0) begin fails++; $display("FAIL restart_idx: got %0d expected 0", idx_a); end
  endtask

  task automatic test_scan();
    int e;
    logic [3:0] oh;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      e  = (cyc / 4) % 4;
      oh = 4'b0001 << e;
      tests++; if (idx_a !== 2'(e)) begin fails++; $display("FAIL scan_idx: got %0d expected %0d", idx_a, e); end
      tests++; if (dig_a !== ~oh) begin fails++; $display("FAIL scan_dig: got %b expected %b", dig_a, ~oh); end
      tests++; if (seg_a !== t1234[e]) begin fails++; $display("FAIL scan_seg idx=%0d: got %h expected %h", e, seg_a, t1234[e]); end
    end
    $display("[TB] scan 1234 checked over 16 clks");
  endtask

  task automatic test_latch();
    int e;
    le = 1'b1;
    @(negedge clk);
    bcd_in = 16'h9999;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      e = (cyc / 4) % 4;
      tests++; if (seg_a !== t1234[e]) begin fails++; $display("FAIL latch_hold idx=%0d: got %h expected %h", e, seg_a, t1234[e]); end
    end
    le = 1'b0;
    repeat (2) @(negedge clk);
    tests++; if (seg_a !== 8'h67) begin fails++; $display("FAIL latch_open_a: got %h expected 67", seg_a); end
    tests++; if (seg_b !== 8'h98) begin fails++; $display("FAIL latch_open_b: got %h expected 98", seg_b); end
    $display("[TB] latch release: seg_a=%h seg_b=%h", seg_a, seg_b);
  endtask

  task automatic test_priority();
    int e;
    logic [3:0] oh;
    logic [7:0] exp_seg;
    lt_n = 1'b0; bi_n = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      e  = (cyc / 4) % 4;
      oh = 4'b0001 << e;
      tests++; if (seg_a !== 8'hFF) begin fails++; $display("FAIL lamp_test_seg: got %h expected ff", seg_a); end
      tests++; if (dig_a !== ~oh) begin fails++; $display("FAIL lamp_test_dig: got %b expected %b", dig_a, ~oh); end
      tests++; if (seg_b !== 8'h00) begin fails++; $display("FAIL lamp_test_seg_b: got %h expected 00", seg_b); end
    end
    lt_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      tests++; if (seg_a !== 8'h00) begin fails++; $display("FAIL blank_seg: got %h expected 00", seg_a); end
    end
    bi_n = 1'b1; bcd_in = 16'hBBBB;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      tests++; if (seg_a !== 8'h00) begin fails++; $display("FAIL code_b_seg: got %h expected 00", seg_a); end
      @(negedge clk);
    end
    bcd_in = 16'h1234; dp_in = 4'b0100;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 16; k++) begin
      e = (cyc / 4) % 4;
      exp_seg = t1234[e] | ((e == 2) ? 8'h80 : 8'h00);
      tests++; if (seg_a !== exp_seg) begin fails++; $display("FAIL dp_seg idx=%0d: got %h expected %h", e, seg_a, exp_seg); end
      @(negedge clk);
    end
    $display("[TB] priority lt/bi/code B/dp checked");
  endtask

  task automatic test_lzb();
    int e;
    logic [15:0] vec [3] = '{16'h0050, 16'h0000, 16'h0405};
    logic [7:0]  tbl [3][4] = '{'{8'h3F, 8'h6D, 8'h00, 8'h00},
                                 '{8'h3F, 8'h00, 8'h00, 8'h00},
                                 '{8'h6D, 8'h3F, 8'h66, 8'h00}};
    lzb_en = 1'b1; dp_in = 4'b0000;
    for (int v = 0; v < 3; v++) begin
      bcd_in = vec[v];
      repeat (2) @(negedge clk);
      for (int k = 0; k < 16; k++) begin
        e = (cyc / 4) % 4;
        tests++; if (seg_a !== tbl[v][e]) begin fails++; $display("FAIL lzb %h idx=%0d: got %h expected %h", vec[v], e, seg_a, tbl[v][e]); end
        @(negedge clk);
      end
      $display("[TB] lzb bcd=%h checked", vec[v]);
    end
    lzb_en = 1'b0;
  endtask

  task automatic test_polarity();
    int e;
    logic [3:0] oh;
    bcd_in = 16'h8888;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      e  = cyc % 4;
      oh = 4'b0001 << e;
      tests++; if (idx_b !== 2'(e)) begin fails++; $display("FAIL pol_idx_b: got %0d expected %0d", idx_b, e); end
      tests++; if (dig_b !== oh) begin fails++; $display("FAIL pol_dig_b: got %b expected %b", dig_b, oh); end
      tests++; if (seg_b !== 8'h80) begin fails++; $display("FAIL pol_seg_b: got %h expected 80", seg_b); end
      @(negedge clk);
    end
    $display("[TB] inverted polarity, CLK_DIV=1 checked over 8 clks");
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish within 200000 time units");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_scan();
    test_latch();
    test_priority();
    test_lzb();
    test_polarity();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Multi-digit, time-multiplexed 7-segment display driver. It is the clocked, parametrised successor of the team's single-digit BCD decoder and keeps 4511-style semantics: latch enable, lamp test and blanking. It adds per-digit BCD and decimal-point latching, a prescaled scan counter, digit-select generation, leading-zero blanking and configurable output polarity. It sits between the datapath's packed BCD result and the board's common-anode or common-cathode display pins.

Parameters:
DIGITS, 4, number of display digits (1..8); digit 0 is least significant, bcd_in[3:0].
CLK_DIV, 50000, clk cycles per scan step (>=1); 1 advances the scan every cycle.
SEG_ACTIVE_LOW, 0, 1 inverts all of seg[7:0] at the output register.
DIG_ACTIVE_LOW, 1, 1 makes the dig select active-low.

Ports:
clk      in   1           system clock; single clock domain, all logic on the rising edge
rst      in   1           asynchronous, active-high reset
bcd_in   in   4*DIGITS    packed BCD digits
dp_in    in   DIGITS      decimal point per digit
le       in   1           latch enable; 0 = transparent, 1 = hold
lt_n     in   1           lamp test, active low
bi_n     in   1           blanking, active low
lzb_en   in   1           leading-zero blanking enable
seg      out  8           seg[0]=a .. seg[6]=g, seg[7]=dp; registered
dig      out  DIGITS      one-hot digit select; registered
scan_idx out  max(1,$clog2(DIGITS))  currently driven digit index; registered

Behaviour:
- Reset (async, immediate, no clock required):
  - prescaler = 0, scan_idx = 0, latches = 0.
  - seg = all segments off after polarity is applied (0x00, or 0xFF if SEG_ACTIVE_LOW).
  - dig = all digits off after polarity is applied.
- Prescaler:
  - Counts 0..CLK_DIV-1.
  - tick = (count == CLK_DIV-1); count wraps to 0 on tick.
- Scan index:
  - scan_idx increments on tick; DIGITS-1 wraps to 0.
  - First tick occurs CLK_DIV cycles after reset release.
- Latch:
  - On every clk with le=0, the latch captures bcd_in and dp_in.
  - With le=1 the latch holds.
  - le rising and a data change in the same cycle: the old (previously captured) value is kept.
- Decode (4511-compatible, active-high, before polarity):
  - 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7C, 7=0x07, 8=0x7F, 9=0x67.
  - Codes A..F decode to 0x00 (blank).
  - seg[7] = latched dp of the selected digit.
- Priority (highest first):
  1. lt_n=0: seg=0xFF, including dp.
  2. bi_n=0: seg=0x00.
  3. Leading-zero blank: seg=0x00.
  4. Normal decode.
- Leading-zero blanking: digit i (i>0) is blanked when lzb_en=1 and the latched digits DIGITS-1..i are all 0. Digit 0 is never blanked.
- Digit select during lt/bi: dig keeps scanning.
- Output register and latency:
  - seg, dig and scan_idx are registered together and are always mutually consistent.
  - lt_n/bi_n/lzb_en change to seg: 1 clk.
  - bcd_in change to seg (le=0, digit selected): 2 clk.
- CLK_DIV=1 and DIGITS=1 must synthesise and function; with DIGITS=1, dig is constant on.

Decomposition:
- Package seg7_pkg holds:
  - segment code constants SEG_0..SEG_9, SEG_BLANK=0x00, SEG_ALL=0xFF;
  - segment bit-index constants SEG_A..SEG_DP;
  - a function bcd_to_seg(4-bit) returning 7 bits.
- One combinational sub-module, seg7_decode: bcd, dp, lt_n, bi_n, blank -> 8-bit seg, implementing the priority chain.
- Prescaler, scan counter, latch, LZB chain and output register live in the top.

Test Plan:
1. Reset (DIGITS=4, CLK_DIV=4, defaults): hold rst, then release -> seg=0x00, dig=4'b1111. scan_idx=0 until the first tick 4 clks after release. Asserting rst asynchronously mid-scan at idx 2 -> outputs off with no clock edge; scan restarts at idx 0.
2. Scan: bcd_in=16'h1234, le=0, lt_n=bi_n=1, lzb_en=0 -> the following sequence repeats with period 16 clks:

   | dig  | seg  | digit |
   |------|------|-------|
   | 1110 | 0x66 | 4     |
   | 1101 | 0x4F | 3     |
   | 1011 | 0x5B | 2     |
   | 0111 | 0x06 | 1     |

3. Latch: set le=1, then bcd_in=16'h9999 -> the 1234 patterns persist. Set le=0 -> 0x67 on the selected digit within 2 clks.
4. Priority:
   - lt_n=0, bi_n=0 -> seg=0xFF on all digits.
   - lt_n=1, bi_n=0 -> 0x00.
   - digit code 4'hB -> 0x00.
   - dp_in=4'b0100 -> seg=0x80|code on digit 2 only.
5. Leading-zero blanking, lzb_en=1:
   - bcd_in=16'h0050 -> digits 3,2 = 0x00; digit1 = 0x6D; digit0 = 0x3F.
   - bcd_in=16'h0000 -> only digit0 = 0x3F.
   - bcd_in=16'h0405 -> digit3 blank; digit2 = 0x66; digit1 = 0x3F (inner zero shown).
6. Polarity: SEG_ACTIVE_LOW=1, DIG_ACTIVE_LOW=0, digit 8 -> seg=0x80, selected dig bit=1. CLK_DIV=1 -> scan_idx advances every clk.
